// File: rtl/wave_capture_writer.sv
// rtl/wave_capture_writer.sv - circular ADC sample writer with pre-trigger history and level trigger.
// Defining WAVE_CAPTURE_FORCE_TRIG_EN adds the force_trig input.
module wave_capture_writer #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 8,
    parameter int PRE_TRIG = 128
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
    input  logic              force_trig,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(DEPTH - PRE_TRIG - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] ptr, count, post_cnt;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              capturing, accept, level_hit, force_hit, trig_hit;

    always_comb begin
        capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
        accept    = capturing && sample_valid && !arm;
        if (trig_rising)
            level_hit = prev_valid && (prev < trig_level) && (sample >= trig_level);
        else
            level_hit = prev_valid && (prev > trig_level) && (sample <= trig_level);
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
        force_hit = force_trig;
`else
        force_hit = 1'b0;
`endif
        trig_hit = accept && (state == S_WAIT) && (level_hit || force_hit);
    end

    always_comb begin
        state_nx = state;
        if (arm) begin
            state_nx = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
        end else if (accept) begin
            case (state)
                S_PRE:   if (count == PRE_LAST) state_nx = S_WAIT;
                S_WAIT:  if (trig_hit) state_nx = (POST_INIT == '0) ? S_DONE : S_POST;
                S_POST:  if (post_cnt == ADDR_W'(1)) state_nx = S_DONE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            count      <= '0;
            post_cnt   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            state <= state_nx;
            wr_en <= accept;
            // busy trails the state by one cycle so it covers the final write strobe
            busy  <= arm || capturing;
            done  <= !arm && (state == S_DONE);
            if (accept) begin
                wr_addr    <= ptr;
                wr_data    <= sample;
                ptr        <= ptr + 1'b1;
                prev       <= sample;
                prev_valid <= 1'b1;
                if (state == S_PRE)  count    <= count + 1'b1;
                if (state == S_POST) post_cnt <= post_cnt - 1'b1;
            end
            if (trig_hit) begin
                trig_addr  <= ptr;
                start_addr <= ptr - PRE_OFF;
                triggered  <= 1'b1;
                post_cnt   <= POST_INIT;
            end
            if (arm) begin
                ptr        <= '0;
                count      <= '0;
                prev_valid <= 1'b0;
                triggered  <= 1'b0;
            end
        end
    end
endmodule
